// File: rtl/timer_display.sv
// Purpose: mm:ss / hh:mm BCD timer with prescaled step, load, up/down count and a 4-digit muxed 7-seg driver.
// Latency: tick/done/bcd update one cycle after the prescaler terminal edge; seg/an/dp are combinational from registers.
// Backpressure: none; run=0 freezes prescaler and value while the display scan keeps running.
module timer_display #(
    parameter int PERIOD    = 50_000_000,
    parameter int MODE      = 0,
    parameter int SCAN_BITS = 18,
    parameter int BLANK_LZ  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] bcd,
    output logic        tick,
    output logic        done,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(PERIOD / 2);

    logic [PW-1:0]        pre;
    logic [SCAN_BITS-1:0] scan;
    logic                 step;
    logic                 load_ok;
    logic [15:0]          step_val;
    logic [1:0]           sel;
    logic [3:0]           digit;

    // A load value is accepted only if every digit is within its range for the mode.
    function automatic logic valid_bcd(input logic [15:0] v);
        logic ok;
        ok = (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5) && (v[11:8] <= 4'd9);
        if (MODE == 0)
            ok = ok && (v[15:12] <= 4'd5);
        else
            ok = ok && (v[15:12] <= 4'd2) && !((v[15:12] == 4'd2) && (v[11:8] > 4'd3));
        return ok;
    endfunction

    // Ripple increment; in hh:mm the hours-ones digit wraps at 3 when hours-tens is 2.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [3:0] d0, d1, d2, d3, d2_max, d3_max;
        {d3, d2, d1, d0} = v;
        d3_max = (MODE == 0) ? 4'd5 : 4'd2;
        d2_max = ((MODE != 0) && (d3 == 4'd2)) ? 4'd3 : 4'd9;
        if (d0 != 4'd9) begin
            d0 = d0 + 4'd1;
        end else begin
            d0 = 4'd0;
            if (d1 != 4'd5) begin
                d1 = d1 + 4'd1;
            end else begin
                d1 = 4'd0;
                if (d2 != d2_max) begin
                    d2 = d2 + 4'd1;
                end else begin
                    d2 = 4'd0;
                    d3 = (d3 == d3_max) ? 4'd0 : d3 + 4'd1;
                end
            end
        end
        return {d3, d2, d1, d0};
    endfunction

    // Ripple decrement that saturates at 0000, so the top digit never borrows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] d0, d1, d2, d3;
        {d3, d2, d1, d0} = v;
        if (v != 16'h0000) begin
            if (d0 != 4'd0) begin
                d0 = d0 - 4'd1;
            end else begin
                d0 = 4'd9;
                if (d1 != 4'd0) begin
                    d1 = d1 - 4'd1;
                end else begin
                    d1 = 4'd5;
                    if (d2 != 4'd0) begin
                        d2 = d2 - 4'd1;
                    end else begin
                        d2 = 4'd9;
                        d3 = d3 - 4'd1;
                    end
                end
            end
        end
        return {d3, d2, d1, d0};
    endfunction

    assign step     = run && (pre == PRE_MAX);
    assign load_ok  = load && valid_bcd(load_val);
    assign step_val = up ? bcd_inc(bcd) : bcd_dec(bcd);

    // Prescaler, count value and step pulses; a valid load restarts the period and swallows the step.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre  <= '0;
            bcd  <= 16'h0000;
            tick <= 1'b0;
            done <= 1'b0;
        end else if (load_ok) begin
            pre  <= '0;
            bcd  <= load_val;
            tick <= 1'b0;
            done <= 1'b0;
        end else begin
            if (run)
                pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
            tick <= step;
            done <= step && !up && (bcd != 16'h0000) && (step_val == 16'h0000);
            if (step)
                bcd <= step_val;
        end
    end

    // Free-running display scan, independent of run.
    always_ff @(posedge clk) begin
        if (rst)
            scan <= '0;
        else
            scan <= scan + 1'b1;
    end

    assign sel = scan[SCAN_BITS-1:SCAN_BITS-2];

    // Digit select, segment decode, leading-zero blanking and colon marker on d2.
    always_comb begin
        digit = bcd[3:0];
        an    = 4'b1110;
        dp    = 1'b1;
        seg   = 7'b0111111;
        case (sel)
            2'd0: begin digit = bcd[3:0];   an = 4'b1110; end
            2'd1: begin digit = bcd[7:4];   an = 4'b1101; end
            2'd2: begin digit = bcd[11:8];  an = 4'b1011; end
            default: begin digit = bcd[15:12]; an = 4'b0111; end
        endcase
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        if ((BLANK_LZ != 0) && (sel == 2'd3) && (bcd[15:12] == 4'd0))
            seg = 7'b1111111;
        if (sel == 2'd2)
            dp = run ? (pre >= PRE_HALF) : 1'b0;
    end

endmodule

// File: tb/tb_timer_display.sv
// Directed bench: two instances (mm:ss without blanking, hh:mm with blanking) sharing one stimulus stream.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Every check is inline; summary line reports errors and total checks.
module tb_timer_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;

    logic [15:0] bcd0, bcd1;
    logic        tick0, tick1, done0, done1, dp0, dp1;
    logic [6:0]  seg0, seg1;
    logic [3:0]  an0, an1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timer_display #(.PERIOD(4), .MODE(0), .SCAN_BITS(4), .BLANK_LZ(0)) u0 (
        .clk(clk), .rst(rst), .run(run), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd0), .tick(tick0), .done(done0), .seg(seg0), .dp(dp0), .an(an0)
    );

    timer_display #(.PERIOD(4), .MODE(1), .SCAN_BITS(4), .BLANK_LZ(1)) u1 (
        .clk(clk), .rst(rst), .run(run), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd1), .tick(tick1), .done(done1), .seg(seg1), .dp(dp1), .an(an1)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_val = v;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(3);
        checks++; if (bcd0 !== 16'h0000) begin errors++; $display("FAIL reset_bcd got=%h exp=0000", bcd0); end
        checks++; if (tick0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_pulses tick=%b done=%b exp=0,0", tick0, done0); end
        checks++; if (an0 !== 4'b1110) begin errors++; $display("FAIL reset_an got=%b exp=1110", an0); end
        checks++; if (seg0 !== 7'b1000000) begin errors++; $display("FAIL reset_seg got=%b exp=1000000", seg0); end
        checks++; if (dp0 !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp0); end
        checks++; if (bcd1 !== 16'h0000 || an1 !== 4'b1110) begin errors++; $display("FAIL reset_u1 bcd=%h an=%b exp=0000,1110", bcd1, an1); end
        rst = 1'b0;
    endtask

    task automatic test_up_count;
        logic [15:0] exp;
        run = 1'b1;
        up  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            exp = (k < 10) ? 16'(k) : 16'h0010;
            cyc(3);
            checks++; if (tick0 !== 1'b0) begin errors++; $display("FAIL up_tick_idle k=%0d got=%b exp=0", k, tick0); end
            cyc(1);
            checks++; if (tick0 !== 1'b1 || bcd0 !== exp) begin errors++; $display("FAIL up_step k=%0d tick=%b bcd=%h exp=1,%h", k, tick0, bcd0, exp); end
        end
        do_load(16'h5959);
        cyc(3);
        checks++; if (bcd0 !== 16'h5959 || tick0 !== 1'b0) begin errors++; $display("FAIL up_load5959 bcd=%h tick=%b exp=5959,0", bcd0, tick0); end
        cyc(1);
        checks++; if (bcd0 !== 16'h0000 || tick0 !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL up_wrap bcd=%h tick=%b done=%b exp=0000,1,0", bcd0, tick0, done0); end
    endtask

    task automatic test_mode1_wrap;
        do_load(16'h2359);
        checks++; if (bcd1 !== 16'h2359) begin errors++; $display("FAIL m1_load2359 got=%h exp=2359", bcd1); end
        cyc(4);
        checks++; if (bcd1 !== 16'h0000 || tick1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL m1_wrap bcd=%h tick=%b done=%b exp=0000,1,0", bcd1, tick1, done1); end
        checks++; if (bcd0 !== 16'h2400) begin errors++; $display("FAIL m0_2359_step got=%h exp=2400", bcd0); end
        do_load(16'h1959);
        cyc(4);
        checks++; if (bcd1 !== 16'h2000 || tick1 !== 1'b1) begin errors++; $display("FAIL m1_1959_step bcd=%h tick=%b exp=2000,1", bcd1, tick1); end
        do_load(16'h2400);
        checks++; if (bcd1 !== 16'h2000 || tick1 !== 1'b0) begin errors++; $display("FAIL m1_invalid_load bcd=%h tick=%b exp=2000,0", bcd1, tick1); end
        checks++; if (bcd0 !== 16'h2400) begin errors++; $display("FAIL m0_load2400 got=%h exp=2400", bcd0); end
        up = 1'b0;
        do_load(16'h1000);
        cyc(4);
        checks++; if (bcd1 !== 16'h0959 || tick1 !== 1'b1) begin errors++; $display("FAIL m1_down1000 bcd=%h tick=%b exp=0959,1", bcd1, tick1); end
    endtask

    task automatic test_down_zero;
        up = 1'b0;
        do_load(16'h0002);
        cyc(4);
        checks++; if (bcd0 !== 16'h0001 || tick0 !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL dn_0001 bcd=%h tick=%b done=%b exp=0001,1,0", bcd0, tick0, done0); end
        cyc(4);
        checks++; if (bcd0 !== 16'h0000 || tick0 !== 1'b1 || done0 !== 1'b1) begin errors++; $display("FAIL dn_zero bcd=%h tick=%b done=%b exp=0000,1,1", bcd0, tick0, done0); end
        cyc(1);
        checks++; if (done0 !== 1'b0 || bcd0 !== 16'h0000) begin errors++; $display("FAIL dn_done_width done=%b bcd=%h exp=0,0000", done0, bcd0); end
        cyc(3);
        checks++; if (bcd0 !== 16'h0000 || tick0 !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL dn_sat bcd=%h tick=%b done=%b exp=0000,1,0", bcd0, tick0, done0); end
        do_load(16'h1000);
        cyc(4);
        checks++; if (bcd0 !== 16'h0959 || done0 !== 1'b0) begin errors++; $display("FAIL dn_1000 bcd=%h done=%b exp=0959,0", bcd0, done0); end
    endtask

    task automatic test_pause;
        int seen;
        cyc(2);
        run  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (tick0 !== 1'b0 || bcd0 !== 16'h0959) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL pause_hold bad_cycles=%0d exp=0 bcd=%h", seen, bcd0); end
        run = 1'b1;
        cyc(1);
        checks++; if (tick0 !== 1'b0) begin errors++; $display("FAIL resume_early got=%b exp=0", tick0); end
        cyc(1);
        checks++; if (tick0 !== 1'b1 || bcd0 !== 16'h0958) begin errors++; $display("FAIL resume_step tick=%b bcd=%h exp=1,0958", tick0, bcd0); end
    endtask

    task automatic test_scan_decode;
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        int n;
        an_tab[0] = 4'b1110; seg_tab[0] = 7'b0011001;
        an_tab[1] = 4'b1101; seg_tab[1] = 7'b0110000;
        an_tab[2] = 4'b1011; seg_tab[2] = 7'b0100100;
        an_tab[3] = 4'b0111; seg_tab[3] = 7'b1111001;
        run = 1'b0;
        up  = 1'b1;
        do_load(16'h1234);
        n = 0;
        while (an0 !== 4'b0111 && n < 32) begin cyc(1); n++; end
        while (an0 !== 4'b1110 && n < 64) begin cyc(1); n++; end
        checks++; if (an0 !== 4'b1110) begin errors++; $display("FAIL scan_align timeout an=%b exp=1110", an0); end
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (an0 !== an_tab[d] || seg0 !== seg_tab[d] || dp0 !== (d == 2 ? 1'b0 : 1'b1)) begin
                    errors++;
                    $display("FAIL scan d=%0d c=%0d an=%b seg=%b dp=%b exp=%b,%b,%b", d, c, an0, seg0, dp0,
                             an_tab[d], seg_tab[d], (d == 2 ? 1'b0 : 1'b1));
                end
                cyc(1);
            end
        end
        do_load(16'h0234);
        n = 0;
        while (an1 !== 4'b0111 && n < 32) begin cyc(1); n++; end
        checks++; if (an1 !== 4'b0111 || seg1 !== 7'b1111111) begin errors++; $display("FAIL blank_lz an=%b seg=%b exp=0111,1111111", an1, seg1); end
        checks++; if (an0 !== 4'b0111 || seg0 !== 7'b1000000) begin errors++; $display("FAIL no_blank an=%b seg=%b exp=0111,1000000", an0, seg0); end
    endtask

    task automatic test_reset_mid;
        run = 1'b1;
        up  = 1'b1;
        do_load(16'h0005);
        cyc(3);
        rst = 1'b1;
        load = 1'b1;
        load_val = 16'h1111;
        cyc(1);
        checks++; if (bcd0 !== 16'h0000 || tick0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL rstmid_regs bcd=%h tick=%b done=%b exp=0000,0,0", bcd0, tick0, done0); end
        checks++; if (an0 !== 4'b1110 || seg0 !== 7'b1000000 || dp0 !== 1'b1) begin errors++; $display("FAIL rstmid_disp an=%b seg=%b dp=%b exp=1110,1000000,1", an0, seg0, dp0); end
        rst  = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_mode1_wrap();
        test_down_zero();
        test_pause();
        test_scan_decode();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_display.md
# timer_display

Parametrised mm:ss / hh:mm timer with a 4-digit multiplexed 7-segment driver. It runs entirely in the `clk` domain. A prescaler produces a one-cycle count enable every `PERIOD` cycles. The block supports up or down counting with BCD load, and flags the count-down reaching zero. It sits between board push-buttons/switches and the 4-digit common-anode display, and replaces the fixed 50 MHz minute/second counter.

## Interface
- `PERIOD`, default 50_000_000: clk cycles per count step; must be at least 2.
- `MODE`, default 0: 0 = MM:SS (digit limits 5,9,5,9); 1 = HH:MM (00–23, 00–59).
- `SCAN_BITS`, default 18: scan counter width, at least 3. Each digit is shown for 2^(SCAN_BITS-2) cycles.
- `BLANK_LZ`, default 0: 1 blanks the most-significant digit when it is 0.
- Reset is `rst`, synchronous, active-high. The clock is `clk`.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous active-high reset.
- `run`, in, 1: 1 lets the prescaler advance; 0 freezes the prescaler and the value.
- `up`, in, 1: 1 counts up; 0 counts down.
- `load`, in, 1: load `load_val` this cycle.
- `load_val`, in, 16: BCD {d3,d2,d1,d0}.
- `bcd`, out, 16: current value {d3,d2,d1,d0}.
- `tick`, out, 1: one-cycle pulse when a count step occurs.
- `done`, out, 1: one-cycle pulse when a down-count reaches 0000.
- `seg`, out, 7: {g,f,e,d,c,b,a}, active low.
- `dp`, out, 1: decimal point, active low.
- `an`, out, 4: digit enables, active low.

## Operation
- **Prescaler** `pre` is `$clog2(PERIOD)` bits wide. When `run`=1 it counts 0..PERIOD-1 and wraps. When `run`=0 it holds. A step fires on the edge where `pre`==PERIOD-1 and `run`=1.
- **Priority per edge:** `rst` > `load` > step.
- **Load:** if `load_val` is valid for `MODE` (every nibble ≤ its digit limit, and in MODE 1 also hours ≤ 23), then `bcd` ← `load_val`, `pre` ← 0, and the step in that cycle is discarded. If invalid, the load is ignored entirely and the step proceeds normally.
- **Up step:** ripple BCD increment with per-digit limits.
  - MODE 0: 59:59 → 00:00.
  - MODE 1: 23:59 → 00:00, with the hours ones digit wrapping at 3 when the tens digit is 2.
  - `done` never fires when counting up.
- **Down step:** ripple BCD decrement.
  - MODE 0: 10:00 → 09:59.
  - MODE 1: 10:00 → 09:59, and hours 00 borrow is not possible because the count saturates first.
  - A step that produces 0000 pulses `done`.
  - A down step at 0000 leaves the value unchanged, with no `done`, but `tick` still pulses.
- **Scan:** a free-running counter `scan` (SCAN_BITS wide) that ignores `run`. `scan[SCAN_BITS-1:SCAN_BITS-2]` selects the digit: 00 → d0/`an`=1110, 01 → d1/1101, 10 → d2/1011, 11 → d3/0111.
- **Segment decode (gfedcba):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Anything else = 0111111 (dash).
  - With `BLANK_LZ`=1, d3==0 gives `seg`=1111111 while d3 is selected (`an` is still driven).
- **`dp`** is a colon marker on d2 only:
  - While `run`=1: lit (0) when `pre` < PERIOD/2, dark otherwise.
  - While `run`=0: lit steadily on d2.
  - Dark (1) on all other digits.

## Timing
- **Reset values:** `bcd`=0000, `pre`=0, `scan`=0, `tick`=0, `done`=0, `an`=1110, `seg`=1000000, `dp`=1.
- `tick`, `done` and the new `bcd` all become visible in the same cycle: one cycle after the edge where `pre`==PERIOD-1. The step period is exactly PERIOD cycles when `run` is held at 1.
- `run` deasserted mid-period preserves `pre`. On resume, the next step arrives after the remaining cycles.
- `load` takes effect on the next edge. The first step after a load comes PERIOD cycles later (with `run`=1).
- `rst` mid-count clears everything on the next edge, regardless of `load` or `run`.
- `seg`, `an` and `dp` are combinational from the registers: they update in the same cycle that `scan` or `bcd` changes, with no added latency.
- `up` is sampled only on step edges. A change between steps has no other effect.

## Test plan
- **Up count, MODE 0:** PERIOD=4, SCAN_BITS=4, `run`=1, `up`=1 from reset → `tick` every 4 cycles; `bcd` 0000→0001…0009→0010; after load 5959 plus one step → 0000, `done`=0.
- **MODE 1 wrap:** load 2359, one step → 0000; load 1959, one step → 2000; load 2400 → ignored, `bcd` unchanged.
- **Down to zero:** load 0002, `up`=0 → 0001, then 0000 with `done`=1 for exactly 1 cycle; the next step keeps 0000 with `tick`=1, `done`=0; load 1000, one step → 0959.
- **Pause/resume:** drop `run` with `pre`=2 for 10 cycles → no `tick` and `bcd` held; the step arrives 2 cycles after `run` returns.
- **Scan/decode:** `bcd`=1234, SCAN_BITS=4 → `an`/`seg` cycle 1110/0011001, 1101/0110000, 1011/0100100, 0111/1111001, 4 cycles each; `BLANK_LZ`=1 with `bcd`=0234 → `seg`=1111111 during `an`=0111.
- **Reset mid-operation:** assert `rst` together with `load`=1 and a step edge → all outputs return to reset values the next cycle.
